// File: rtl/pu_msp430_pkg.sv
// Shared types and defaults for the MSP430-style per-channel clock gating controller.
package pu_msp430_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OFF   = 2'd2,
    WAKE  = 2'd3
  } ch_state_t;

  localparam int DEF_NCH         = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_WAKE_CYCLES = 2;

endpackage

// File: rtl/pu_msp430_clock_gate_ctrl_if.sv
// Channel-activity inputs, gated clocks and status of the clock gating controller.
interface pu_msp430_clock_gate_ctrl_if #(
  parameter int NCH = 4
);
  // wake_req/wake_ack are a four-phase pair per channel: the requester raises
  // wake_req and holds it until wake_ack is high, then drops it; wake_ack
  // falls one clock after wake_req falls, and a new request may then start.
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   force_on;
  logic [NCH-1:0]   wake_req;
  logic             gate_bypass;
  logic             scan_enable;
  logic [NCH-1:0]   gclk;
  logic [NCH-1:0]   wake_ack;
  logic [NCH-1:0]   gated;
  logic [2*NCH-1:0] state_dbg;

  modport master (
    output busy, force_on, wake_req, gate_bypass, scan_enable,
    input  gclk, wake_ack, gated, state_dbg
  );

  modport slave (
    input  busy, force_on, wake_req, gate_bypass, scan_enable,
    output gclk, wake_ack, gated, state_dbg
  );
endinterface

// File: rtl/pu_msp430_clock_gate.sv
// Glitch-free clock gate cell: enable captured by a low-phase latch, then ANDed with clk.
module pu_msp430_clock_gate (
  input  logic clk,
  input  logic en,
  input  logic scan_enable,
  output logic gclk
);

  logic en_l;

  // Latch is closed while clk is high, so an enable change only shows on the next high phase.
  always_latch begin
    if (!clk) en_l = en | scan_enable;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/pu_msp430_clock_gate_ctrl.sv
// Per-channel idle/wake clock gating controller: one RUN/DRAIN/OFF/WAKE FSM and gate cell per channel.
module pu_msp430_clock_gate_ctrl
  import pu_msp430_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic                         clk,
  input  logic                         puc_rst,
  pu_msp430_clock_gate_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("NCH must be in 1..16");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 1..2^CNT_W-1");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_wake
    $error("WAKE_CYCLES must be in 1..2^CNT_W-1");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wake_ack_q, wake_ack_d;
    logic             gated_q, gated_d;
    logic             act;
    logic             gate_en;

    assign act = bus.busy[i] | bus.force_on[i] | bus.wake_req[i];

    always_ff @(posedge clk) begin
      if (puc_rst) begin
        state_q    <= RUN;
        cnt_q      <= '0;
        wake_ack_q <= 1'b0;
        gated_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        wake_ack_q <= wake_ack_d;
        gated_q    <= gated_d;
      end
    end

    // Activity in DRAIN is tested before cnt==0 so a late reassertion never loses a pulse.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        RUN: begin
          if (!act) begin
            state_d = DRAIN;
            cnt_d   = IDLE_LOAD;
          end
        end
        DRAIN: begin
          if (act)                state_d = RUN;
          else if (cnt_q == '0)   state_d = OFF;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        OFF: begin
          if (act) begin
            state_d = WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
        WAKE: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = RUN;
      endcase
    end

    // gated is registered from the next state so it always equals ~gate_en.
    always_comb begin
      gate_en    = (state_q != OFF);
      gated_d    = (state_d == OFF);
      wake_ack_d = bus.wake_req[i] & (state_q == RUN);
    end

    pu_msp430_clock_gate u_gate (
      .clk         (clk),
      .en          (gate_en | bus.gate_bypass),
      .scan_enable (bus.scan_enable),
      .gclk        (bus.gclk[i])
    );

    assign bus.wake_ack[i]         = wake_ack_q;
    assign bus.gated[i]            = gated_q;
    assign bus.state_dbg[2*i +: 2] = state_q;
  end

endmodule

// File: tb/tb_pu_msp430_clock_gate_ctrl.sv
// Directed bench for pu_msp430_clock_gate_ctrl with default parameters; edges counted from the first one.
module tb_pu_msp430_clock_gate_ctrl;
  import pu_msp430_pkg::*;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic puc_rst;

  int n_checks = 0;
  int n_fail   = 0;

  int             gclk_rises [NCH];
  logic [NCH-1:0] gclk_prev = 'x;
  int             snap;

  pu_msp430_clock_gate_ctrl_if #(.NCH(NCH)) bus ();

  pu_msp430_clock_gate_ctrl #(
    .NCH         (NCH),
    .CNT_W       (4),
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (2)
  ) dut (
    .clk     (clk),
    .puc_rst (puc_rst),
    .bus     (bus)
  );

  // clock / reset: posedges at 5,15,25,... so every legal gclk rise is at t%10==5
  always #5 clk = ~clk;

  // glitch monitor: gclk may only rise with clk's rise and only fall with clk's fall
  always @(bus.gclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus.gclk[i] === 1'b1 && gclk_prev[i] === 1'b0) begin
        gclk_rises[i]++;
        n_checks++;
        assert (($time % 10) === 64'd5) else begin
          n_fail++;
          $error("FAIL glitch_rise ch%0d: observed t%%10=%0d expected 5", i, $time % 10);
        end
      end else if (bus.gclk[i] === 1'b0 && gclk_prev[i] === 1'b1) begin
        n_checks++;
        assert (($time % 10) === 64'd0) else begin
          n_fail++;
          $error("FAIL glitch_fall ch%0d: observed t%%10=%0d expected 0", i, $time % 10);
        end
      end
    end
    gclk_prev = bus.gclk;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] st(input int ch);
    return bus.state_dbg[2*ch +: 2];
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) gclk_rises[i] = 0;
    puc_rst          = 1'b1;
    bus.busy         = '0;
    bus.force_on     = '0;
    bus.wake_req     = '0;
    bus.gate_bypass  = 1'b0;
    bus.scan_enable  = 1'b0;

    // reset: clocks run, no status
    tick(1);                                       // E1
    check("rst_gated_e1", 32'(bus.gated), 32'h0);
    tick(1);                                       // E2
    check("rst_gated", 32'(bus.gated), 32'h0);
    check("rst_ack", 32'(bus.wake_ack), 32'h0);
    check("rst_gclk", 32'(bus.gclk), 32'hF);
    check("rst_state", 32'(bus.state_dbg), 32'h0);

    // release with no activity: E3 enters DRAIN, OFF after E3+8 = E11
    puc_rst = 1'b0;
    tick(8);                                       // E10
    check("idle_gated_e10", 32'(bus.gated), 32'h0);
    check("idle_state0_e10", 32'(st(0)), 32'(DRAIN));
    tick(1);                                       // E11
    check("idle_gated_e11", 32'(bus.gated), 32'hF);
    check("idle_state0_e11", 32'(st(0)), 32'(OFF));
    tick(1);                                       // E12
    check("idle_gclk_off", 32'(bus.gclk), 32'h0);

    // busy wakes channel 0 from OFF at E13
    bus.busy[0] = 1'b1;
    tick(1);                                       // E13
    check("wake0_gated", 32'(bus.gated), 32'hE);
    check("wake0_state", 32'(st(0)), 32'(WAKE));
    tick(1);                                       // E14
    check("wake0_gclk", 32'(bus.gclk), 32'h1);
    tick(1);                                       // E15
    check("wake0_run", 32'(st(0)), 32'(RUN));

    // busy low E16..E20, high again at E21 = k+5: never gated
    bus.busy[0] = 1'b0;
    tick(1);                                       // E16
    check("drain0_state", 32'(st(0)), 32'(DRAIN));
    tick(4);                                       // E20
    check("drain0_gated_e20", 32'(bus.gated[0]), 32'h0);
    bus.busy[0] = 1'b1;
    tick(1);                                       // E21
    check("drain0_back_run", 32'(st(0)), 32'(RUN));
    check("drain0_gated_e21", 32'(bus.gated[0]), 32'h0);

    // busy reasserted exactly on the cnt==0 edge (E30): no pulse lost
    snap = gclk_rises[0];
    bus.busy[0] = 1'b0;
    tick(8);                                       // E29
    check("edge0_state_e29", 32'(st(0)), 32'(DRAIN));
    bus.busy[0] = 1'b1;
    tick(1);                                       // E30
    check("edge0_state_e30", 32'(st(0)), 32'(RUN));
    check("edge0_gated_e30", 32'(bus.gated[0]), 32'h0);
    tick(2);                                       // E32
    check("edge0_pulses", 32'(gclk_rises[0] - snap), 32'd11);

    // wake handshake on channel 1: req sampled at m = E33
    bus.wake_req[1] = 1'b1;
    tick(1);                                       // E33
    check("wake1_state_m", 32'(st(1)), 32'(WAKE));
    check("wake1_ack_m", 32'(bus.wake_ack[1]), 32'h0);
    tick(1);                                       // E34
    check("wake1_gclk", 32'(bus.gclk[1]), 32'h1);
    tick(1);                                       // E35
    check("wake1_run_m2", 32'(st(1)), 32'(RUN));
    check("wake1_ack_m2", 32'(bus.wake_ack[1]), 32'h0);
    tick(1);                                       // E36
    check("wake1_ack_m3", 32'(bus.wake_ack[1]), 32'h1);
    bus.wake_req[1] = 1'b0;
    tick(1);                                       // E37
    check("wake1_ack_fall", 32'(bus.wake_ack[1]), 32'h0);
    check("wake1_drain", 32'(st(1)), 32'(DRAIN));
    tick(7);                                       // E44
    check("wake1_gated_e44", 32'(bus.gated[1]), 32'h0);
    tick(1);                                       // E45
    check("wake1_gated_e45", 32'(bus.gated[1]), 32'h1);

    // all channels OFF, then scan and bypass overrides
    bus.busy[0] = 1'b0;
    tick(9);                                       // E54
    check("all_off_gated", 32'(bus.gated), 32'hF);
    tick(1);                                       // E55
    check("all_off_gclk", 32'(bus.gclk), 32'h0);
    bus.scan_enable = 1'b1;
    tick(1);                                       // E56
    check("scan_gclk", 32'(bus.gclk), 32'hF);
    check("scan_gated", 32'(bus.gated), 32'hF);
    check("scan_state", 32'(bus.state_dbg), 32'hAA);
    bus.scan_enable = 1'b0;
    bus.gate_bypass = 1'b1;
    tick(1);                                       // E57
    check("byp_gclk", 32'(bus.gclk), 32'hF);
    check("byp_gated", 32'(bus.gated), 32'hF);
    check("byp_state", 32'(bus.state_dbg), 32'hAA);
    bus.gate_bypass = 1'b0;
    tick(1);                                       // E58
    check("regate_gclk", 32'(bus.gclk), 32'h0);
    check("regate_state", 32'(bus.state_dbg), 32'hAA);

    // reset in the middle of a wake on channel 2
    bus.wake_req[2] = 1'b1;
    tick(1);                                       // E59
    check("rstwake_state", 32'(st(2)), 32'(WAKE));
    puc_rst = 1'b1;
    tick(1);                                       // E60
    check("rstwake_run", 32'(bus.state_dbg), 32'h0);
    check("rstwake_ack", 32'(bus.wake_ack), 32'h0);
    check("rstwake_gated", 32'(bus.gated), 32'h0);
    puc_rst = 1'b0;
    bus.wake_req[2] = 1'b0;
    tick(1);                                       // E61
    check("post_rst_ack", 32'(bus.wake_ack), 32'h0);
    check("post_rst_gclk", 32'(bus.gclk), 32'hF);

    // force_on keeps channel 3 clocked while the others drain to OFF at E69
    bus.force_on[3] = 1'b1;
    tick(9);                                       // E70
    check("force_gated", 32'(bus.gated), 32'h7);
    check("force_state3", 32'(st(3)), 32'(RUN));
    bus.force_on[3] = 1'b0;
    tick(2);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_msp430_clock_gate_ctrl.md
PU_MSP430_CLOCK_GATE_CTRL -- requirements
Module: pu_msp430_clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independently gated clock channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 4: idle/wake counter width in bits.
REQ-003 SHALL have parameter IDLE_CYCLES, default 8: idle cycles before gating (1..2^CNT_W-1).
REQ-004 SHALL have parameter WAKE_CYCLES, default 2: settle cycles before wake acknowledge (1..2^CNT_W-1).
REQ-005 SHALL have port clk, input, 1: single clock; one clock; all state on rising edge.
REQ-006 SHALL have port puc_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port busy, input, NCH: per-channel activity; high keeps the channel clock running.
REQ-008 SHALL have port force_on, input, NCH: per-channel software override; high keeps the clock on.
REQ-009 SHALL have port wake_req, input, NCH: per-channel four-phase wake request.
REQ-010 SHALL have port gate_bypass, input, 1: global debug override; all channels ungated.
REQ-011 SHALL have port scan_enable, input, 1: scan shift; all gates transparent.
REQ-012 SHALL have port gclk, output, NCH: gated clocks.
REQ-013 SHALL have port wake_ack, output, NCH: per-channel wake acknowledge.
REQ-014 SHALL have port gated, output, NCH: status; high while the channel clock is stopped.

Function
REQ-015 Each channel SHALL run an independent FSM with states RUN, DRAIN, OFF and WAKE, plus a CNT_W-bit counter.
REQ-016 Channel activity SHALL be act = busy | force_on | wake_req.
REQ-017 RUN: gate_en=1; !act -> DRAIN with cnt=IDLE_CYCLES-1; else stay.
REQ-018 DRAIN: gate_en=1; act -> RUN; else cnt==0 -> OFF; else cnt decrements.
REQ-019 OFF: gate_en=0; act -> WAKE with cnt=WAKE_CYCLES-1.
REQ-020 WAKE: gate_en=1; cnt==0 -> RUN; else cnt decrements; act dropping in WAKE does not abort the wake.
REQ-021 Latency: act sampled low at edge k with no reassertion SHALL give gate_en low after edge k+IDLE_CYCLES.
REQ-022 Latency: act sampled high at edge m in OFF SHALL give gate_en high after edge m and state RUN after edge m+WAKE_CYCLES.
REQ-023 Any act in DRAIN SHALL win over cnt==0 on the same edge: the channel stays clocked and goes to RUN.
REQ-024 wake_ack SHALL be registered as (wake_req & state==RUN), so it rises one edge after RUN is entered with the request high.
REQ-025 wake_ack SHALL fall one edge after wake_req falls.
REQ-026 The requester SHALL hold wake_req until wake_ack is seen; a channel with wake_req high never leaves RUN.
REQ-027 The effective enable SHALL be gate_en | gate_bypass | scan_enable.
REQ-028 gate_bypass and scan_enable SHALL NOT alter FSM state or counters.
REQ-029 gclk SHALL be produced by a low-phase-latch plus AND gate per channel, so an enable change affects only the next high phase of clk (glitch-free).
REQ-030 gated SHALL be registered and SHALL equal ~gate_en (FSM-based, independent of bypass and scan).
REQ-031 Channels SHALL NOT interact; simultaneous events on different channels SHALL be handled independently.

Reset
REQ-032 On puc_rst, all channels SHALL enter RUN with cnt=0, gate_en=1, wake_ack=0 and gated=0, so clocks run during reset.
REQ-033 Reset SHALL take priority over all inputs, including mid-DRAIN and mid-WAKE, and SHALL be synchronous only.

Structure
REQ-034 A shared package pu_msp430_pkg SHALL hold the channel-state enum typedef (RUN, DRAIN, OFF, WAKE) and the default constants for IDLE_CYCLES and WAKE_CYCLES.
REQ-035 One sub-module SHALL be instantiated per channel: pu_msp430_clock_gate (latch + AND, with scan_enable input), generated NCH times.
REQ-036 Parameter legality (IDLE_CYCLES and WAKE_CYCLES in range) SHALL be checked at elaboration.

Verification
REQ-037 Reset, then busy=0: all gated=0 during reset; gated[i] rises after edge 8 following release (defaults).
REQ-038 busy[0] drops at edge k, rises at edge k+5: gated[0] stays 0 and FSM returns to RUN.
REQ-039 busy[0] reasserts exactly at the cnt==0 edge: no gclk[0] pulse is lost (REQ-023).
REQ-040 Channel 1 OFF, wake_req[1]=1 at edge m: gclk[1] toggles from the next high phase; wake_ack[1]=1 after edge m+3; drop req; ack falls one edge later; gating resumes 8 edges after that.
REQ-041 All channels OFF, scan_enable=1 then gate_bypass=1: all gclk toggle; gated stays 1 and FSM is unchanged; deassertion re-gates on the next high phase.
REQ-042 puc_rst asserted mid-WAKE on channel 2: next edge gives RUN, gate_en=1, wake_ack=0; an assertion-based glitch check on all gclk passes throughout.
